// File: rtl/neos2test_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neos2test_sysid_pkg
// Description : Shared types and constants for the system-ID checker.
//               State encoding of the read-master FSM, default build-time
//               expected words and the byte offset of the timestamp word.
// Revision    : 1.0 - initial release
// ============================================================================
package neos2test_sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'h3939_3939;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h557D_3514;

    // Byte distance from the ID word to the timestamp word.
    localparam logic [31:0] WORD_OFFSET     = 32'd4;

endpackage
`default_nettype wire

// File: rtl/neos2test_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module      : neos2test_sysid_checker
// Description : Avalon-MM read master that fetches the system-ID word and the
//               timestamp word, compares them with build-time expected values
//               and reports pass/fail. Each read is bounded by a stall timeout.
//
// Ports
//   clk_i              : sole clock
//   rst_ni             : synchronous active-low reset
//   start_i            : one-cycle check request, honoured only in IDLE
//   avm_address_o      : byte address (BASE_ADDR / BASE_ADDR+4, else 0)
//   avm_read_o         : read strobe
//   avm_waitrequest_i  : slave stall
//   avm_readdata_i     : read data, valid when read && !waitrequest
//   busy_o             : check in progress
//   done_o             : one-cycle pulse at completion
//   pass_o             : both words matched in the last check
//   id_ok_o, ts_ok_o   : per-word match of the last check
//   timeout_err_o      : last check aborted on a stall timeout
//   id_value_o         : last captured ID word
//   ts_value_o         : last captured timestamp word
//   fail_count_o       : saturating count of failed checks since reset
//
// Revision    : 1.0 - initial release
// ============================================================================
module neos2test_sysid_checker
    import neos2test_sysid_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT     = 255,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [31:0] avm_address_o,
    output logic        avm_read_o,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        id_ok_o,
    output logic        ts_ok_o,
    output logic        timeout_err_o,
    output logic [31:0] id_value_o,
    output logic [31:0] ts_value_o,
    output logic [7:0]  fail_count_o
);

    localparam logic [31:0] TS_ADDR  = BASE_ADDR + WORD_OFFSET;
    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic        auto_arm_q;
    logic        auto_fire_q;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  fail_q, fail_d;

    logic        w_accept;
    logic        w_stall;
    logic        w_timeout;

    // Bus strobes are pure decodes of the state register, so they drop in
    // the very cycle after a reset is sampled.
    always_comb begin
        avm_read_o    = 1'b0;
        avm_address_o = 32'h0;
        case (state_q)
            ST_RD_ID: begin
                avm_read_o    = 1'b1;
                avm_address_o = BASE_ADDR;
            end
            ST_RD_TS: begin
                avm_read_o    = 1'b1;
                avm_address_o = TS_ADDR;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

    assign w_accept  = avm_read_o & ~avm_waitrequest_i;
    assign w_stall   = avm_read_o &  avm_waitrequest_i;
    // stall_q counts stalls already seen; this stall is number stall_q+1.
    assign w_timeout = w_stall && (({1'b0, stall_q} + 17'd1) == TO_LIMIT);

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        fail_d     = fail_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i || auto_fire_q) begin
                    state_d   = ST_RD_ID;
                    stall_d   = 16'h0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            ST_RD_ID: begin
                if (w_accept) begin
                    id_value_d = avm_readdata_i;
                    id_ok_d    = (avm_readdata_i == EXPECTED_ID);
                    stall_d    = 16'h0;
                    state_d    = ST_RD_TS;
                end else if (w_timeout) begin
                    timeout_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    stall_d    = stall_q + 16'd1;
                end
            end
            ST_RD_TS: begin
                if (w_accept) begin
                    ts_value_d = avm_readdata_i;
                    ts_ok_d    = (avm_readdata_i == EXPECTED_TS);
                    state_d    = ST_DONE;
                end else if (w_timeout) begin
                    timeout_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    stall_d    = stall_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Verdict is registered on the edge into DONE so pass and
        // fail_count are already valid while done is high.
        if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            pass_d = id_ok_d & ts_ok_d & ~timeout_d;
            if (!pass_d && (fail_q != 8'hFF)) begin
                fail_d = fail_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            stall_q     <= 16'h0;
            auto_arm_q  <= 1'b1;
            auto_fire_q <= 1'b0;
            id_value_q  <= 32'h0;
            ts_value_q  <= 32'h0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_q      <= 8'h0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            // Armed latch fires exactly once, one cycle after reset release.
            auto_arm_q  <= 1'b0;
            auto_fire_q <= auto_arm_q & AUTO_START;
            id_value_q  <= id_value_d;
            ts_value_q  <= ts_value_d;
            id_ok_q     <= id_ok_d;
            ts_ok_q     <= ts_ok_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            fail_q      <= fail_d;
        end
    end

    assign pass_o        = pass_q;
    assign id_ok_o       = id_ok_q;
    assign ts_ok_o       = ts_ok_q;
    assign timeout_err_o = timeout_q;
    assign id_value_o    = id_value_q;
    assign ts_value_o    = ts_value_q;
    assign fail_count_o  = fail_q;

endmodule
`default_nettype wire
